exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline; consumes the ID/EX register outputs.
- Contains:
  - the Val2 generator (immediate rotate, register shift, memory offset);
  - a 32-bit ALU;
  - the architectural NZCV status register;
  - the branch-target adder;
  - the EX/MEM pipeline register with freeze.
- Produces the redirect to IF, flags to ID, and registered results to MEM.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- RD_W, 4, destination register index width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  holds the EX/MEM register and the status register (MEM-stage stall).
- pc_in  in  32  PC+4 of the instruction in EX.
- wb_en_in, mem_r_in, mem_w_in, b_in, s_in, imm_in  in  1 each  control bits from ID/EX.
- exec_cmd_in  in  4  ALU command.
- val_rn_in, val_rm_in  in  32  operand values.
- rd_in  in  4  destination register.
- shift_operand_in  in  12  operand-2 field.
- signed_imm_24_in  in  24  branch offset.
- status_in  in  4  NZCV snapshot captured in ID; its C is the carry-in.
- branch_taken  out  1  combinational, equals b_in.
- branch_addr  out  32  combinational branch target.
- status_out  out  4  registered NZCV, fed to ID condition check.
- wb_en_out, mem_r_out, mem_w_out  out  1  registered.
- alu_res_out  out  32  registered ALU result / memory address.
- val_rm_out  out  32  registered store data.
- rd_out  out  4  registered destination.

Behaviour:
- Reset (async, rst=1): every registered output and the status register clear to 0 immediately. A reset mid-instruction discards that instruction.
- Latency: exactly 1 cycle from ID/EX outputs to the EX/MEM outputs.
- Val2 generation:
  - imm_in=1: zero-extend shift_operand[7:0] to 32 bits, then rotate right by 2*shift_operand[11:8]. A rotate amount of 0 passes the value unchanged.
  - imm_in=0 and (mem_r_in|mem_w_in): zero-extend shift_operand[11:0].
  - Otherwise: shift val_rm_in by shift_operand[11:7] using type shift_operand[6:5]:
    - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
    - An amount of 0 passes val_rm_in unchanged for all four types.
- ALU exec_cmd encoding:
  - 0001 MOV: V2
  - 1001 MVN: ~V2
  - 0010 ADD / LDR / STR: Rn+V2
  - 0011 ADC: Rn+V2+C
  - 0100 SUB / CMP: Rn-V2
  - 0101 SBC: Rn-V2-(~C)
  - 0110 AND / TST: Rn&V2
  - 0111 ORR: Rn|V2
  - 1000 EOR: Rn^V2
  - Any other code: result 0, flags N=0 Z=1 C=0 V=0.
- Flags:
  - N = res[31]; Z = (res==0).
  - C = carry out of bit 31 for add; NOT borrow for subtract; 0 for logical/move.
  - V = signed overflow for arithmetic; 0 otherwise.
  - All arithmetic is computed in 33 bits, modulo 2^32.
- Status register: on a rising edge with s_in=1 and freeze=0, it loads the ALU flags. Otherwise it holds. A flush bubble arrives with s_in=0, so it never writes.
- Branch target: branch_addr = pc_in + sign_extend(signed_imm_24_in)<<2. Wrap-around is modulo 2^32. The output is valid regardless of b_in.
- EX/MEM register:
  - freeze=0: captures wb_en_in, mem_r_in, mem_w_in, ALU result, val_rm_in, rd_in.
  - freeze=1: holds all outputs; the status register is also held.
  - freeze and a new s_in in the same cycle: the status write is suppressed. ID must re-present the instruction.

Decomposition:
- Shared package (arm_pkg): exec_cmd codes, shift-type codes, and NZCV bit indices.
- One natural sub-module: val2_gen (combinational, shift/rotate logic). ALU, status register and EX/MEM register stay inline.

Test Plan:
- Reset: rst=1 mid-stream, with all inputs nonzero -> all outputs 0 and status_out=0000 without waiting for a clock edge.
- Immediate rotate: imm=1, shift_operand=0x2FF, MOV -> alu_res_out=0xF000000F one cycle later; status unchanged while s_in=0.
- Flags: SUB with s_in=1, Rn=5, Rm=5, shift field 0 -> alu_res_out=0, status_out=0110 (Z=1, C=1). ADD with s_in=1, Rn=0x7FFFFFFF, imm 1 -> alu_res_out=0x80000000, status_out=1001.
- Carry-in: ADC, Rn=1, Rm=1, status_in C=1 -> alu_res_out=3. SBC, Rn=5, Rm=2, C=0 -> alu_res_out=2.
- Memory offset and freeze:
  - STR, imm=0, shift_operand=0xFFC, Rn=0x100 -> alu_res_out=0x10FC and val_rm_out=val_rm_in.
  - Then freeze=1 for 2 cycles with changed inputs and s_in=1 -> alu_res_out, val_rm_out and status_out unchanged.
- Branch: pc_in=0x20, b_in=1, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0x18. imm24=0x000001 -> branch_addr=0x24.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset pipeline: ALU commands, shift types and
// NZCV bit positions, plus the rotate helper the execute stage uses.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right; an amount of 0 returns the value untouched.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] w;
    w = {v, v} >> amt;
    return w[31:0];
  endfunction

endpackage

// File: rtl/val2_gen.sv
// Operand-2 generator: rotated immediate, memory offset, or shifted Rm.
module val2_gen
  import arm_pkg::*;
(
  input  logic        imm_i,
  input  logic        mem_i,
  input  logic [11:0] shift_operand_i,
  input  logic [31:0] val_rm_i,
  output logic [31:0] val2_o
);

  logic [4:0]  sh_amt;
  logic [1:0]  sh_type;
  logic [31:0] imm_rot;
  logic [31:0] reg_sh;

  assign sh_amt  = shift_operand_i[11:7];
  assign sh_type = shift_operand_i[6:5];
  assign imm_rot = ror32({24'd0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});

  always_comb begin
    reg_sh = val_rm_i;
    case (sh_type)
      SH_LSL:  reg_sh = val_rm_i << sh_amt;
      SH_LSR:  reg_sh = val_rm_i >> sh_amt;
      SH_ASR:  reg_sh = $unsigned($signed(val_rm_i) >>> sh_amt);
      default: reg_sh = ror32(val_rm_i, sh_amt);
    endcase
  end

  assign val2_o = imm_i ? imm_rot :
                  mem_i ? {20'd0, shift_operand_i} : reg_sh;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch-target
// adder and the freezable EX/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en_in,
  input  logic              mem_r_in,
  input  logic              mem_w_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic              imm_in,
  input  logic [3:0]        exec_cmd_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        status_in,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status_out,
  output logic              wb_en_out,
  output logic              mem_r_out,
  output logic              mem_w_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [RD_W-1:0]   rd_out
);

  logic [DATA_W-1:0] val2;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              c_f;
  logic              v_f;
  logic              cin;
  logic [3:0]        flags;

  logic [3:0]        status_q;
  logic              wb_en_q, mem_r_q, mem_w_q;
  logic [DATA_W-1:0] alu_res_q, val_rm_q;
  logic [RD_W-1:0]   rd_q;

  val2_gen u_val2_gen (
    .imm_i           (imm_in),
    .mem_i           (mem_r_in | mem_w_in),
    .shift_operand_i (shift_operand_in),
    .val_rm_i        (val_rm_in),
    .val2_o          (val2)
  );

  assign cin = status_in[FLAG_C];

  // Subtracts are done as Rn + ~V2 + 1 so the carry out is directly NOT-borrow.
  always_comb begin
    sum = '0;
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (exec_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, val_rn_in} + {1'b0, val2}
            + {{DATA_W{1'b0}}, (exec_cmd_in == CMD_ADC) & cin};
        res = sum[DATA_W-1:0];
        c_f = sum[DATA_W];
        v_f = (val_rn_in[DATA_W-1] == val2[DATA_W-1]) && (res[DATA_W-1] != val_rn_in[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, val_rn_in} + {1'b0, ~val2}
            + {{DATA_W{1'b0}}, (exec_cmd_in == CMD_SBC) ? cin : 1'b1};
        res = sum[DATA_W-1:0];
        c_f = sum[DATA_W];
        v_f = (val_rn_in[DATA_W-1] != val2[DATA_W-1]) && (res[DATA_W-1] != val_rn_in[DATA_W-1]);
      end
      CMD_AND: res = val_rn_in & val2;
      CMD_ORR: res = val_rn_in | val2;
      CMD_EOR: res = val_rn_in ^ val2;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = res[DATA_W-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = c_f;
    flags[FLAG_V] = v_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else if (s_in && !freeze) begin
      status_q <= flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      alu_res_q <= '0;
      val_rm_q  <= '0;
      rd_q      <= '0;
    end else if (!freeze) begin
      wb_en_q   <= wb_en_in;
      mem_r_q   <= mem_r_in;
      mem_w_q   <= mem_w_in;
      alu_res_q <= res;
      val_rm_q  <= val_rm_in;
      rd_q      <= rd_in;
    end
  end

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  assign status_out  = status_q;
  assign wb_en_out   = wb_en_q;
  assign mem_r_out   = mem_r_q;
  assign mem_w_out   = mem_w_q;
  assign alu_res_out = alu_res_q;
  assign val_rm_out  = val_rm_q;
  assign rd_out      = rd_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus random vectors
// scored against a behavioural model through an expected-result queue.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_r_in, mem_w_in, b_in, s_in, imm_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] val_rn_in, val_rm_in;
  logic [3:0]  rd_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  status_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_out;
  logic        wb_en_out, mem_r_out, mem_w_out;
  logic [31:0] alu_res_out, val_rm_out;
  logic [3:0]  rd_out;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  rd;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  st;
  } exp_t;

  exp_t q_exp[$];
  exp_t mdl;
  int   n_checks = 0;
  int   n_fail   = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_r_in(mem_r_in), .mem_w_in(mem_w_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exec_cmd_in(exec_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .rd_in(rd_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .status_in(status_in), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .status_out(status_out), .wb_en_out(wb_en_out), .mem_r_out(mem_r_out),
    .mem_w_out(mem_w_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] v;
    int n;
    if (imm) begin
      v = {24'd0, so[7:0]};
      n = 2 * so[11:8];
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
      return v;
    end
    if (mem) return {20'd0, so};
    v = rm;
    n = so[11:7];
    for (int i = 0; i < n; i++) begin
      case (so[6:5])
        2'b00:   v = {v[30:0], 1'b0};
        2'b01:   v = {1'b0, v[31:1]};
        2'b10:   v = {v[31], v[31:1]};
        default: v = {v[0], v[31:1]};
      endcase
    end
    return v;
  endfunction

  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, output logic [31:0] r, output logic [3:0] f);
    longint ua, ub, us, sa, sb, ss, bor;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    bor = cin ? 0 : 1;
    c = 1'b0; v = 1'b0; r = '0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        us = ua + ub + ((cmd == 4'b0011 && cin) ? 1 : 0);
        ss = sa + sb + ((cmd == 4'b0011 && cin) ? 1 : 0);
        r = us[31:0]; c = us[32];
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        if (cmd == 4'b0100) bor = 0;
        us = ua - ub - bor;
        ss = sa - sb - bor;
        r = us[31:0]; c = (ua >= ub + bor);
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: r = '0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] m_baddr(input logic [31:0] pc, input logic [23:0] off);
    int o;
    o = $signed(off);
    return pc + 32'(o * 4);
  endfunction

  // Check the combinational branch outputs, push the model's view of the
  // EX/MEM register after the next edge, then compare it against the DUT.
  task automatic step();
    exp_t e;
    logic [31:0] r;
    logic [3:0]  f;
    #1;
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, b_in});
    chk("branch_addr", branch_addr, m_baddr(pc_in, signed_imm_24_in));
    m_alu(exec_cmd_in, val_rn_in, m_val2(imm_in, mem_r_in | mem_w_in, shift_operand_in, val_rm_in),
          status_in[1], r, f);
    if (!freeze) begin
      mdl.alu = r; mdl.rm = val_rm_in; mdl.rd = rd_in;
      mdl.wb = wb_en_in; mdl.mr = mem_r_in; mdl.mw = mem_w_in;
      if (s_in) mdl.st = f;
    end
    q_exp.push_back(mdl);
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = q_exp.pop_front();
      chk("alu_res_out", alu_res_out, e.alu);
      chk("val_rm_out", val_rm_out, e.rm);
      chk("rd_out", {28'd0, rd_out}, {28'd0, e.rd});
      chk("ctl_out", {29'd0, wb_en_out, mem_r_out, mem_w_out}, {29'd0, e.wb, e.mr, e.mw});
      chk("status_out", {28'd0, status_out}, {28'd0, e.st});
    end
  endtask

  task automatic setv(input logic [3:0] cmd, input logic imm, input logic mr, input logic mw,
                      input logic s, input logic [31:0] rn, input logic [31:0] rm,
                      input logic [11:0] so);
    exec_cmd_in = cmd; imm_in = imm; mem_r_in = mr; mem_w_in = mw; s_in = s;
    val_rn_in = rn; val_rm_in = rm; shift_operand_in = so;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; pc_in = 32'h0; b_in = 1'b0;
    wb_en_in = 1'b1; rd_in = 4'h3; signed_imm_24_in = 24'd0; status_in = 4'b0000;
    setv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'd0);
    mdl = '0;
    #12;
    chk("rst_alu", alu_res_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    setv(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 12'h2FF);
    step();
    chk("imm_rot_const", alu_res_out, 32'hF000000F);
    chk("imm_rot_status", {28'd0, status_out}, 32'h0);

    setv(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 12'h000);
    step();
    chk("sub_const", alu_res_out, 32'd0);
    chk("sub_flags", {28'd0, status_out}, 32'b0110);

    setv(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd0, 12'h001);
    step();
    chk("add_ovf_const", alu_res_out, 32'h80000000);
    chk("add_ovf_flags", {28'd0, status_out}, 32'b1001);

    status_in = 4'b0010;
    setv(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 12'h000);
    step();
    chk("adc_const", alu_res_out, 32'd3);

    status_in = 4'b0000;
    setv(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd2, 12'h000);
    step();
    chk("sbc_const", alu_res_out, 32'd2);

    wb_en_in = 1'b0; rd_in = 4'h9;
    setv(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 12'hFFC);
    step();
    chk("str_addr_const", alu_res_out, 32'h10FC);
    chk("str_data_const", val_rm_out, 32'hDEADBEEF);

    freeze = 1'b1; wb_en_in = 1'b1; rd_in = 4'h2;
    setv(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 32'd7, 12'h000);
    step();
    setv(4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h55, 12'h0AA);
    step();
    chk("freeze_alu_const", alu_res_out, 32'h10FC);
    chk("freeze_rm_const", val_rm_out, 32'hDEADBEEF);
    chk("freeze_status_const", {28'd0, status_out}, 32'b1001);
    freeze = 1'b0;

    setv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h80000000, 12'h240);
    step();
    chk("asr4_const", alu_res_out, 32'hF8000000);
    setv(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h12345678, 12'h460);
    step();
    chk("ror8_const", alu_res_out, 32'h78123456);
    setv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd9, 32'd3, 12'h000);
    step();
    chk("bad_cmd_flags", {28'd0, status_out}, 32'b0100);

    pc_in = 32'h20; b_in = 1'b1; signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("br_taken_const", {31'd0, branch_taken}, 32'd1);
    chk("br_back_const", branch_addr, 32'h18);
    signed_imm_24_in = 24'h000001;
    #1;
    chk("br_fwd_const", branch_addr, 32'h24);
    b_in = 1'b0;

    for (int i = 0; i < 60; i++) begin
      pc_in = $urandom; b_in = 1'($urandom_range(0, 1));
      signed_imm_24_in = 24'($urandom); status_in = 4'($urandom);
      wb_en_in = 1'($urandom_range(0, 1)); rd_in = 4'($urandom);
      freeze = ($urandom_range(0, 4) == 0);
      setv(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)) & ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom, $urandom, 12'($urandom));
      step();
    end
    freeze = 1'b0;

    pc_in = 32'hFFFF_FFF0; b_in = 1'b1; signed_imm_24_in = 24'h000008;
    #1;
    chk("br_wrap_const", branch_addr, 32'h10);

    status_in = 4'hF; wb_en_in = 1'b1; rd_in = 4'hA;
    setv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF, 32'hABCD, 12'h0FF);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_alu", alu_res_out, 32'd0);
    chk("midrst_rm", val_rm_out, 32'd0);
    chk("midrst_rd", {28'd0, rd_out}, 32'd0);
    chk("midrst_ctl", {29'd0, wb_en_out, mem_r_out, mem_w_out}, 32'd0);
    chk("midrst_status", {28'd0, status_out}, 32'd0);
    mdl = '0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    setv(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 12'h000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
